tug_of_war_ctrl: RTL
====================

# tug_of_war_ctrl

Game controller for the two-player tug-of-war board. Takes single-cycle press pulses from the two per-player press-pulse generators and arbitrates them against a shared light position on an LED bar. It detects round wins, keeps per-player round scores, and sequences the match through idle, play, win and game-over phases. Sits between the press-pulse generators and the LED/HEX display drivers.

## Interface

Parameters:
- NUM_LEDS, default 9: LED bar width. Must be odd and ≥ 3. Centre index C = (NUM_LEDS-1)/2.
- SCORE_W, default 3: width of each score counter. Match-winning score MAX = 2^SCORE_W − 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- l_press  in  1  left-player press pulse (one cycle per press, synchronous to clk).
- r_press  in  1  right-player press pulse, same format.
- start  in  1  single-cycle start/continue pulse.
- leds  out  NUM_LEDS  light bar. Bit NUM_LEDS−1 is the leftmost LED.
- l_score  out  SCORE_W  left rounds won.
- r_score  out  SCORE_W  right rounds won.
- winner  out  2  2'b01 = left won last round, 2'b10 = right, 2'b00 = none.
- game_over  out  1  high while the match is finished.

## Operation

- Internal state: pos (0..NUM_LEDS−1); state ∈ {IDLE, PLAY, WIN, OVER}.
- Reset (reset = 0): state = IDLE, pos = C, l_score = r_score = 0, winner = 00, game_over = 0, leds = one-hot bit C.
- IDLE:
  - leds = one-hot(C); presses ignored.
  - start → PLAY, pos = C.
- PLAY, evaluated each cycle:
  - leds = one-hot(pos).
  - l_press only: if pos < NUM_LEDS−1, pos += 1. If pos == NUM_LEDS−1, left wins the round.
  - r_press only: if pos > 0, pos −= 1. If pos == 0, right wins the round.
  - Both or neither: no change. Simultaneous presses cancel.
  - start ignored.
- Round win:
  - Winner's score += 1; winner set to 01 or 10.
  - If the new score == MAX → OVER, otherwise → WIN.
  - Scores never wrap: OVER is entered at MAX.
- WIN:
  - leds = all zeros; winner held; presses ignored.
  - start → PLAY, pos = C, winner = 00. Scores kept.
- OVER:
  - leds = all ones; game_over = 1; winner held; presses ignored.
  - start → IDLE, scores = 0, winner = 00, pos = C, game_over = 0.
- start and a press in the same cycle: the state transition from start applies; the press is discarded.
- Inputs are treated as levels each cycle. A press held high for k cycles in PLAY moves k positions. Pulse shaping is the upstream generator's responsibility.

## Timing

- All outputs are registered (Moore). Inputs sampled at rising edge k are reflected on outputs after edge k: 1-cycle latency.
- Winning press at edge k: scores, winner, leds (0 or all-ones) and game_over all update together after edge k. There is no intermediate edge-LED-off frame.
- start at edge k: new phase visible after edge k; presses count from edge k+1.
- reset low forces the reset values asynchronously, without waiting for clk, and holds them while low. The first update occurs at the first rising edge after release.
- Reset mid-round or mid-OVER discards the round and all scores.

## Test plan

(NUM_LEDS = 9, SCORE_W = 3)
- Reset: drive reset = 0 between edges during PLAY at pos 6 → leds = 9'b000010000, scores 0, winner 00 immediately, before the next edge.
- Left round: start, then 4 l_press pulses → leds = 9'b100000000. 5th pulse → l_score = 1, winner = 01, leds = 0, state WIN.
- Cancellation: in PLAY at C, l_press = r_press = 1 for 3 cycles → leds stays 9'b000010000. Then r_press alone → 9'b000001000.
- Ignored inputs: presses in IDLE and WIN → no change. start in WIN → leds = 9'b000010000, winner = 00, l_score unchanged. start in PLAY → no effect.
- Match end: right wins 7 rounds (5 r_press pulses each, start between rounds) → r_score = 7, game_over = 1, leds = 9'h1FF, winner = 10. Next start → IDLE, scores 0, game_over = 0.
- Same-cycle start+press in IDLE: state becomes PLAY, pos stays C. The next r_press moves the light to 9'b000001000.

Source files
------------

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war game controller. Player presses move a shared light along the LED bar.
// The controller also keeps round scores and steps the match through idle, play, win and over.
module tug_of_war_ctrl #(
    parameter int NUM_LEDS = 9,
    parameter int SCORE_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                l_press,
    input  logic                r_press,
    input  logic                start,
    output logic [NUM_LEDS-1:0] leds,
    output logic [SCORE_W-1:0]  l_score,
    output logic [SCORE_W-1:0]  r_score,
    output logic [1:0]          winner,
    output logic                game_over
);

    localparam int                  POS_W  = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0]    CENTRE = POS_W'((NUM_LEDS - 1) / 2);
    localparam logic [POS_W-1:0]    LAST   = POS_W'(NUM_LEDS - 1);
    localparam logic [SCORE_W-1:0]  MAX    = '1;
    localparam logic [NUM_LEDS-1:0] ONE    = NUM_LEDS'(1);

    typedef enum logic [1:0] {IDLE, PLAY, WIN, OVER} state_t;

    state_t               r_state, w_stateNext;
    logic [POS_W-1:0]     r_pos, w_posNext;
    logic [SCORE_W-1:0]   r_lScore, w_lScoreNext;
    logic [SCORE_W-1:0]   r_rScore, w_rScoreNext;
    logic [1:0]           r_winner, w_winnerNext;
    logic                 w_lOnly, w_rOnly;

    // Simultaneous presses cancel each other out.
    assign w_lOnly = l_press & ~r_press;
    assign w_rOnly = r_press & ~l_press;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_pos    <= CENTRE;
            r_lScore <= '0;
            r_rScore <= '0;
            r_winner <= 2'b00;
        end else begin
            r_state  <= w_stateNext;
            r_pos    <= w_posNext;
            r_lScore <= w_lScoreNext;
            r_rScore <= w_rScoreNext;
            r_winner <= w_winnerNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_posNext    = r_pos;
        w_lScoreNext = r_lScore;
        w_rScoreNext = r_rScore;
        w_winnerNext = r_winner;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = PLAY;
                    w_posNext   = CENTRE;
                end
            end
            PLAY: begin
                if (w_lOnly) begin
                    if (r_pos == LAST) begin
                        w_lScoreNext = r_lScore + 1'b1;
                        w_winnerNext = 2'b01;
                        w_stateNext  = (w_lScoreNext == MAX) ? OVER : WIN;
                    end else begin
                        w_posNext = r_pos + 1'b1;
                    end
                end else if (w_rOnly) begin
                    if (r_pos == '0) begin
                        w_rScoreNext = r_rScore + 1'b1;
                        w_winnerNext = 2'b10;
                        w_stateNext  = (w_rScoreNext == MAX) ? OVER : WIN;
                    end else begin
                        w_posNext = r_pos - 1'b1;
                    end
                end
            end
            WIN: begin
                if (start) begin
                    w_stateNext  = PLAY;
                    w_posNext    = CENTRE;
                    w_winnerNext = 2'b00;
                end
            end
            OVER: begin
                if (start) begin
                    w_stateNext  = IDLE;
                    w_posNext    = CENTRE;
                    w_lScoreNext = '0;
                    w_rScoreNext = '0;
                    w_winnerNext = 2'b00;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Outputs depend only on registered state, so they change one cycle after the inputs.
    always_comb begin
        leds      = '0;
        game_over = 1'b0;
        case (r_state)
            IDLE: leds = ONE << CENTRE;
            PLAY: leds = ONE << r_pos;
            WIN:  leds = '0;
            OVER: begin
                leds      = '1;
                game_over = 1'b1;
            end
            default: leds = '0;
        endcase
    end

    assign l_score = r_lScore;
    assign r_score = r_rScore;
    assign winner  = r_winner;

endmodule
